// File: rtl/apb_pkg.sv
// Shared types for the APB register-file slave: FSM states, error causes, wait-counter width.
package apb_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_e;

   typedef enum logic [1:0] {
      NONE,
      RANGE,
      ALIGN,
      RO_WRITE
   } err_e;

endpackage

// File: rtl/apb_regfile_slave_if.sv
// APB bus bundle between a requester and the register-file slave.
interface apb_regfile_slave_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  PSEL;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [ADDR_W-1:0]     PADDR;
   logic [DATA_W-1:0]     PWDATA;
   logic [DATA_W/8-1:0]   PSTRB;
   logic [DATA_W-1:0]     PRDATA;
   logic                  PREADY;
   logic                  PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_addr_decode.sv
// Combinational address decode: register index plus the first error cause found
// (range beats alignment beats read-only write).
module apb_addr_decode
   import apb_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 8,
   parameter int IDX_W    = 3,
   parameter logic [NUM_REGS-1:0] RO_MASK = NUM_REGS'(8'hC0)
) (
   input  logic [ADDR_W-1:0] paddr_i,
   input  logic              pwrite_i,
   output logic [IDX_W-1:0]  idx_o,
   output err_e              err_o
);
   localparam int BYTES = DATA_W / 8;

   logic [ADDR_W-1:0] full_idx;

   assign full_idx = paddr_i / ADDR_W'(BYTES);
   assign idx_o    = full_idx[IDX_W-1:0];

   always_comb begin
      err_o = NONE;
      if (full_idx >= ADDR_W'(NUM_REGS)) begin
         err_o = RANGE;
      end else if ((paddr_i % ADDR_W'(BYTES)) != '0) begin
         err_o = ALIGN;
      end else if (pwrite_i && RO_MASK[idx_o]) begin
         err_o = RO_WRITE;
      end
   end
endmodule

// File: rtl/apb_regfile_slave.sv
// APB slave fronting NUM_REGS byte-strobed registers; read-only slots return STATUS_IN.
// PREADY/PRDATA/PSLVERR are registered; writes land at the edge ending the DONE cycle.
module apb_regfile_slave
   import apb_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int NUM_REGS    = 8,
   parameter int WAIT_STATES = 0,
   parameter logic [NUM_REGS-1:0] RO_MASK = NUM_REGS'(8'hC0)
) (
   input  logic                         PCLK,
   input  logic                         PRESET,
   apb_regfile_slave_if.slave           bus,
   input  logic [NUM_REGS*DATA_W-1:0]   STATUS_IN,
   output logic [NUM_REGS*DATA_W-1:0]   REG_OUT,
   output logic [NUM_REGS-1:0]          WR_PULSE
);
   localparam int BYTES = DATA_W / 8;
   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                pready_q, pready_d;
   logic                pslverr_q, pslverr_d;
   logic [DATA_W-1:0]   prdata_q, prdata_d;
   logic                wr_pend_q, wr_pend_d;
   logic [IDX_W-1:0]    wr_idx_q, wr_idx_d;
   logic [DATA_W-1:0]   wr_dat_q, wr_dat_d;
   logic [BYTES-1:0]    wr_strb_q, wr_strb_d;
   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   status_a [NUM_REGS];
   logic [NUM_REGS-1:0] wr_pulse_q;

   logic                setup;
   logic                finish;
   logic [IDX_W-1:0]    dec_idx;
   err_e                dec_err;

   apb_addr_decode #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .IDX_W    (IDX_W),
      .RO_MASK  (RO_MASK)
   ) u_decode (
      .paddr_i  (bus.PADDR),
      .pwrite_i (bus.PWRITE),
      .idx_o    (dec_idx),
      .err_o    (dec_err)
   );

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_slice
      assign status_a[i] = STATUS_IN[i*DATA_W +: DATA_W];
      if (RO_MASK[i]) begin : g_ro
         assign REG_OUT[i*DATA_W +: DATA_W] = '0;
      end else begin : g_rw
         assign REG_OUT[i*DATA_W +: DATA_W] = regs_q[i];
      end
   end

   assign setup = bus.PSEL && !bus.PENABLE;

   // cnt_q holds the access cycles still to go, counting the current one, so
   // PREADY rises in access cycle WAIT_STATES+1; zero waits finish from setup.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      finish  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (setup) begin
               cnt_d = CNT_W'(WAIT_STATES);
               if (WAIT_STATES == 0) begin
                  state_d = DONE;
                  finish  = 1'b1;
               end else begin
                  state_d = ACCESS;
               end
            end
         end
         ACCESS: begin
            if (!bus.PSEL) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = DONE;
                  finish  = 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      pready_d  = finish;
      pslverr_d = finish && (dec_err != NONE);
      prdata_d  = '0;
      if (finish && !bus.PWRITE && dec_err == NONE) begin
         prdata_d = RO_MASK[dec_idx] ? status_a[dec_idx] : regs_q[dec_idx];
      end
      wr_pend_d = finish && bus.PWRITE && (dec_err == NONE);
      wr_idx_d  = dec_idx;
      wr_dat_d  = bus.PWDATA;
      wr_strb_d = bus.PSTRB;
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
         wr_pend_q <= 1'b0;
         wr_idx_q  <= '0;
         wr_dat_q  <= '0;
         wr_strb_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
         wr_pend_q <= wr_pend_d;
         wr_idx_q  <= wr_idx_d;
         wr_dat_q  <= wr_dat_d;
         wr_strb_q <= wr_strb_d;
      end
   end

   // The write captured in the DONE-producing cycle commits one edge later.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
         wr_pulse_q <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            wr_pulse_q[i] <= wr_pend_q && (wr_idx_q == IDX_W'(i));
            if (wr_pend_q && (wr_idx_q == IDX_W'(i)) && !RO_MASK[i]) begin
               for (int b = 0; b < BYTES; b++) begin
                  if (wr_strb_q[b]) begin
                     regs_q[i][8*b +: 8] <= wr_dat_q[8*b +: 8];
                  end
               end
            end
         end
      end
   end

   assign bus.PREADY  = pready_q;
   assign bus.PSLVERR = pslverr_q;
   assign bus.PRDATA  = prdata_q;
   assign WR_PULSE    = wr_pulse_q;
endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench: zero-wait and three-wait slaves share one driver; a monitor scores responses.
module tb_apb_regfile_slave;
   import apb_pkg::*;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         which = 1'b0;
   logic         psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [31:0]  paddr = '0, pwdata = '0;
   logic [3:0]   pstrb = '0;
   logic [255:0] status_in = '0;
   logic [255:0] regout0, regout1;
   logic [7:0]   wrp0, wrp1;

   int   vectors = 0;
   int   errs = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   apb_regfile_slave_if #(.ADDR_W(32), .DATA_W(32)) if0 ();
   apb_regfile_slave_if #(.ADDR_W(32), .DATA_W(32)) if1 ();

   assign if0.PSEL = psel && (which == 1'b0);
   assign if1.PSEL = psel && (which == 1'b1);
   assign if0.PENABLE = penable;
   assign if1.PENABLE = penable;
   assign if0.PWRITE = pwrite;
   assign if1.PWRITE = pwrite;
   assign if0.PADDR = paddr;
   assign if1.PADDR = paddr;
   assign if0.PWDATA = pwdata;
   assign if1.PWDATA = pwdata;
   assign if0.PSTRB = pstrb;
   assign if1.PSTRB = pstrb;

   apb_regfile_slave #(.WAIT_STATES(0)) dut0 (
      .PCLK(clk), .PRESET(rst), .bus(if0.slave),
      .STATUS_IN(status_in), .REG_OUT(regout0), .WR_PULSE(wrp0)
   );

   apb_regfile_slave #(.WAIT_STATES(3)) dut1 (
      .PCLK(clk), .PRESET(rst), .bus(if1.slave),
      .STATUS_IN(status_in), .REG_OUT(regout1), .WR_PULSE(wrp1)
   );

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   function automatic logic cur_ready();
      return (which == 1'b0) ? if0.PREADY : if1.PREADY;
   endfunction

   // Scoreboard monitor: every PREADY on the selected slave consumes one expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && cur_ready()) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_pready", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("prdata", (which == 1'b0) ? if0.PRDATA : if1.PRDATA, e.rdata);
            chk("pslverr", (which == 1'b0) ? if0.PSLVERR : if1.PSLVERR, e.err);
         end
      end
   end

   task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] exp_rd,
                       input logic exp_err, input int exp_lat);
      int  lat;
      bit  seen;
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s;
      exp_q.push_back('{rdata: exp_rd, err: exp_err});
      @(posedge clk); #1;
      penable = 1'b1;
      lat = 0;
      seen = 0;
      for (int c = 1; c <= 40 && !seen; c++) begin
         @(negedge clk);
         if (cur_ready()) begin
            seen = 1;
            lat = c;
         end else begin
            @(posedge clk); #1;
         end
      end
      chk("latency", lat, exp_lat);
   endtask

   task automatic idle();
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      status_in[6*32 +: 32] = 32'h0000_CAFE;
      repeat (3) @(negedge clk);
      chk("rst_pready0", if0.PREADY, 0);
      chk("rst_pslverr0", if0.PSLVERR, 0);
      chk("rst_prdata0", if0.PRDATA, 0);
      chk("rst_regout0", |regout0, 0);
      chk("rst_wrpulse0", wrp0, 0);
      chk("rst_pready1", if1.PREADY, 0);
      chk("rst_state1", 64'(dut1.state_q), 64'(IDLE));
      @(posedge clk); #1;
      rst = 1'b0;

      // Full write then read at zero waits; pulse for one cycle only.
      which = 1'b0;
      xfer(1'b1, 32'h04, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 1);
      idle();
      @(negedge clk);
      chk("wr_pulse_r1", wrp0, 8'h02);
      chk("prdata_idle", if0.PRDATA, 0);
      idle();
      @(negedge clk);
      chk("wr_pulse_r1_end", wrp0, 8'h00);
      xfer(1'b0, 32'h04, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 1);
      idle();
      chk("regout_r1", regout0[1*32 +: 32], 32'hDEAD_BEEF);

      // Byte-lane strobes.
      xfer(1'b1, 32'h08, 32'hAABB_CCDD, 4'hF, 32'h0, 1'b0, 1);
      idle();
      xfer(1'b1, 32'h08, 32'h1122_3344, 4'b0101, 32'h0, 1'b0, 1);
      idle();
      xfer(1'b0, 32'h08, 32'h0, 4'h0, 32'hAA22_CC44, 1'b0, 1);
      idle();

      // Three wait states: PREADY in access cycle 4, one cycle wide.
      which = 1'b1;
      xfer(1'b0, 32'h00, 32'h0, 4'h0, 32'h0, 1'b0, 4);
      idle();
      @(negedge clk);
      chk("pready_width", if1.PREADY, 0);
      which = 1'b0;

      // Error writes: read-only, out of range, misaligned.
      xfer(1'b1, 32'h18, 32'h1234_5678, 4'hF, 32'h0, 1'b1, 1);
      idle();
      @(negedge clk);
      chk("wr_pulse_ro", wrp0, 8'h00);
      xfer(1'b1, 32'h20, 32'h1234_5678, 4'hF, 32'h0, 1'b1, 1);
      idle();
      @(negedge clk);
      chk("wr_pulse_range", wrp0, 8'h00);
      xfer(1'b1, 32'h05, 32'h1234_5678, 4'hF, 32'h0, 1'b1, 1);
      idle();
      @(negedge clk);
      chk("wr_pulse_align", wrp0, 8'h00);
      chk("regout_r1_kept", regout0[1*32 +: 32], 32'hDEAD_BEEF);
      chk("regout_r2_kept", regout0[2*32 +: 32], 32'hAA22_CC44);
      chk("regout_r6_ro", regout0[6*32 +: 32], 32'h0);
      xfer(1'b0, 32'h18, 32'h0, 4'h0, 32'h0000_CAFE, 1'b0, 1);
      idle();
      xfer(1'b0, 32'h20, 32'h0, 4'h0, 32'h0, 1'b1, 1);
      idle();

      // Back-to-back write then read with setup right after DONE.
      xfer(1'b1, 32'h0C, 32'h1357_9BDF, 4'hF, 32'h0, 1'b0, 1);
      xfer(1'b0, 32'h0C, 32'h0, 4'h0, 32'h1357_9BDF, 1'b0, 1);
      idle();

      // Abort: PSEL dropped after one access cycle on the waited slave.
      which = 1'b1;
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C;
      pwdata = 32'h5A5A_5A5A; pstrb = 4'hF;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
      repeat (2) @(negedge clk);
      chk("abort_state", 64'(dut1.state_q), 64'(IDLE));
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("abort_pready", if1.PREADY, 0);
         chk("abort_wrpulse", wrp1, 8'h00);
      end
      chk("abort_reg3", regout1[3*32 +: 32], 32'h0);

      // Reset pulsed in the access phase of a write.
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C;
      pwdata = 32'h5A5A_5A5A; pstrb = 4'hF;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_state", 64'(dut1.state_q), 64'(IDLE));
      chk("rst_mid_pready", if1.PREADY, 0);
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("post_rst_pready", if1.PREADY, 0);
         chk("post_rst_wrpulse", wrp1, 8'h00);
      end
      chk("post_rst_reg3", regout1[3*32 +: 32], 32'h0);
      xfer(1'b0, 32'h0C, 32'h0, 4'h0, 32'h0, 1'b0, 4);
      idle();
      which = 1'b0;
      xfer(1'b0, 32'h04, 32'h0, 4'h0, 32'h0, 1'b0, 1);
      idle();

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule

// File: doc/apb_regfile_slave.md
APB_REGFILE_SLAVE -- requirements
Module: apb_regfile_slave

Interface
REQ-001 Parameters SHALL be:
- DATA_W, 32, register and bus data width; multiple of 8.
- ADDR_W, 32, PADDR width.
- NUM_REGS, 8, register count; 1..64.
- WAIT_STATES, 0, extra access-phase cycles inserted before PREADY; 0..15.
- RO_MASK, 8'hC0, bit i set means register i is read-only, NUM_REGS bits wide.
REQ-002 Ports SHALL be:
- PCLK  input  1  clock; all logic on its rising edge.
- PRESET  input  1  asynchronous, active-high reset.
- PSEL  input  1  slave select.
- PENABLE  input  1  access-phase flag.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  ADDR_W  byte address.
- PWDATA  input  DATA_W  write data.
- PSTRB  input  DATA_W/8  byte-lane write strobes.
- PRDATA  output  DATA_W  read data.
- PREADY  output  1  transfer-complete flag.
- PSLVERR  output  1  transfer-error flag, valid only with PREADY.
- STATUS_IN  input  NUM_REGS*DATA_W  hardware values returned for read-only registers.
- REG_OUT  output  NUM_REGS*DATA_W  current contents of all read/write registers; read-only slices are 0.
- WR_PULSE  output  NUM_REGS  one-cycle pulse per register written.

Function
REQ-003 FSM states SHALL be IDLE, ACCESS and DONE, encoded as the shared enum.
REQ-004 In IDLE, a setup cycle (PSEL=1, PENABLE=0) SHALL move the FSM to ACCESS and load the wait counter with WAIT_STATES.
REQ-005 In ACCESS, the counter SHALL decrement each cycle; when it is 0, the FSM SHALL move to DONE with PREADY=1 registered, so that PREADY is high in access cycle WAIT_STATES+1.
REQ-006 DONE SHALL last exactly one cycle, with PREADY=1, and then return to IDLE, so a setup cycle in the next cycle is accepted (back-to-back transfers).
REQ-007 The register index SHALL be PADDR divided by DATA_W/8.
REQ-008 An error SHALL be flagged when the index is >= NUM_REGS, the address is not aligned to DATA_W/8, or a write targets a register with its RO_MASK bit set.
REQ-009 PSLVERR SHALL be 1 only in the DONE cycle of an erroring transfer, and 0 otherwise.
REQ-010 A non-error write SHALL update byte lane b of the target register only where PSTRB[b]=1, at the clock edge ending the DONE cycle.
REQ-011 The same write SHALL pulse WR_PULSE[index] high for the following cycle, even when PSTRB is all zeros.
REQ-012 An erroring write SHALL modify no register and pulse no WR_PULSE bit.
REQ-013 Read data SHALL be registered with PREADY:
- the register value for a read/write register;
- the STATUS_IN slice for a read-only register;
- 0 on error.
REQ-014 PRDATA SHALL be 0 in every cycle except the DONE cycle of a read.
REQ-015 If PSEL falls before DONE (aborted transfer), the FSM SHALL return to IDLE next cycle with no write, no WR_PULSE and PREADY=0.
REQ-016 A setup cycle while not in IDLE SHALL be ignored.
REQ-017 PADDR, PWRITE, PWDATA and PSTRB SHALL be sampled in the DONE-producing cycle; they are required to be stable from setup until completion.

Reset
REQ-018 PRESET=1 SHALL, asynchronously, force:
- FSM to IDLE and wait counter to 0;
- PREADY=0, PSLVERR=0, PRDATA=0;
- all registers to 0, REG_OUT=0 and WR_PULSE=0.
REQ-019 Reset asserted mid-transfer SHALL abandon that transfer with no register update; the first transfer after release SHALL behave as from power-up.

Structure
REQ-020 The FSM state enum, the WAIT_STATES counter width (4) and an error-cause enum (NONE, RANGE, ALIGN, RO_WRITE) SHALL reside in shared package apb_pkg.
REQ-021 Address decode (index, range, alignment and read-only checks) SHALL be a combinational sub-module, apb_addr_decode; the FSM and register array stay in the top.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Write 0xDEADBEEF to 0x04 with PSTRB=4'hF, WAIT_STATES=0, then read 0x04 -> PREADY in access cycle 1, PRDATA=0xDEADBEEF, PSLVERR=0, WR_PULSE[1] one cycle.
- Write 0x11223344 to 0x08 with PSTRB=4'b0101 over register value 0xAABBCCDD -> read returns 0xAA22CC44.
- WAIT_STATES=3, read 0x00 -> PREADY first high in the 4th access cycle, exactly one cycle wide.
- Write to 0x18 (register 6, read-only), to 0x20 (out of range) and to 0x05 (misaligned) -> PSLVERR=1 each time, no register change, WR_PULSE=0; read 0x18 with STATUS_IN slice 0x0000CAFE -> PRDATA=0x0000CAFE.
- Back-to-back write then read, with setup in the cycle after DONE -> both complete, and the read returns the just-written data.
- PRESET pulsed during the access phase of a write of 0x5A5A5A5A to 0x0C, and separately PSEL dropped mid-access -> register 3 stays 0, PREADY stays 0, FSM in IDLE.
